// File: rtl/kf8253_program_sequencer.sv
// Host-side bus master that turns one program/readback request into the 8253 chip-select/strobe sequence.
// Optional build macro KF8253_SEQ_QUEUE_EN adds a 2-entry request FIFO ahead of the sequencer.
module kf8253_program_sequencer #(
  parameter int WR_PULSE = 2,
  parameter int RD_PULSE = 2,
  parameter int RECOVERY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [1:0]  req_counter,
  input  logic [1:0]  req_rw_mode,
  input  logic [2:0]  req_mode,
  input  logic        req_bcd,
  input  logic [15:0] req_count,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic        chip_select_n,
  output logic        read_enable_n,
  output logic        write_enable_n,
  output logic [1:0]  address,
  output logic [7:0]  data_out,
  input  logic [7:0]  data_in
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER, RESP} state_t;

  localparam logic [7:0] WR_LAST  = 8'(WR_PULSE - 1);
  localparam logic [7:0] RD_LAST  = 8'(RD_PULSE - 1);
  localparam logic [7:0] REC_LAST = 8'(RECOVERY - 1);

  state_t      state;
  logic        rst_done;
  logic [7:0]  cnt;
  logic [1:0]  idx;
  logic [1:0]  last_idx;
  logic        cur_read;

  logic        f_op;
  logic [1:0]  f_counter;
  logic [1:0]  f_rw;
  logic [2:0]  f_mode;
  logic        f_bcd;
  logic [15:0] f_count;

  logic [24:0] req_word;
  logic [24:0] src_word;
  logic        src_valid;
  logic        src_op;
  logic [1:0]  src_counter;
  logic [1:0]  src_rw;
  logic [2:0]  src_mode;
  logic        src_bcd;
  logic [15:0] src_count;
  logic        start;
  logic [10:0] first_info;
  logic [10:0] next_info;

  // Access descriptor {is_read, address, write byte} for position ix of a request's bus sequence.
  function automatic logic [10:0] access_info(input logic op, input logic [1:0] ctr,
                                              input logic [1:0] rw, input logic [2:0] mode,
                                              input logic bcd, input logic [15:0] count,
                                              input logic [1:0] ix);
    logic [10:0] r;
    if (ix == 2'd0)
      r = {1'b0, 2'd3, op ? {ctr, 6'd0} : {ctr, rw, mode, bcd}};
    else if (!op)
      r = {1'b0, ctr, (ix == 2'd1 && rw != 2'b10) ? count[7:0] : count[15:8]};
    else
      r = {1'b1, ctr, 8'd0};
    return r;
  endfunction

  function automatic logic [1:0] last_access(input logic op, input logic [1:0] rw);
    if (!op)
      return (rw == 2'b00) ? 2'd0 : ((rw == 2'b11) ? 2'd2 : 2'd1);
    return (rw == 2'b01 || rw == 2'b10) ? 2'd1 : 2'd2;
  endfunction

  assign req_word = {req_op, req_counter, req_rw_mode, req_mode, req_bcd, req_count};
  assign {src_op, src_counter, src_rw, src_mode, src_bcd, src_count} = src_word;
  assign start = (state == IDLE) && src_valid;

`ifdef KF8253_SEQ_QUEUE_EN
  logic [24:0] fifo_q [2];
  logic [1:0]  fifo_cnt;
  logic        push;

  assign req_ready = rst_done && (fifo_cnt != 2'd2);
  assign push      = req_valid && req_ready;
  assign src_valid = (fifo_cnt != 2'd0);
  assign src_word  = fifo_q[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      fifo_cnt <= 2'd0;
    else
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, start};
  end

  // A pop with one entry and a simultaneous push lands the new request straight in the head slot.
  always_ff @(posedge clock) begin
    if (start)
      fifo_q[0] <= (fifo_cnt == 2'd1) ? req_word : fifo_q[1];
    else if (push && fifo_cnt == 2'd0)
      fifo_q[0] <= req_word;
    if (push && (fifo_cnt == 2'd2 || (fifo_cnt == 2'd1 && !start)))
      fifo_q[1] <= req_word;
  end
`else
  assign req_ready = rst_done && (state == IDLE);
  assign src_valid = req_valid && req_ready;
  assign src_word  = req_word;
`endif

  always_ff @(posedge clock) begin
    if (start)
      {f_op, f_counter, f_rw, f_mode, f_bcd, f_count} <= src_word;
  end

  assign first_info = access_info(src_op, src_counter, src_rw, src_mode, src_bcd, src_count, 2'd0);
  assign next_info  = access_info(f_op, f_counter, f_rw, f_mode, f_bcd, f_count, idx + 2'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      rst_done       <= 1'b0;
      chip_select_n  <= 1'b1;
      read_enable_n  <= 1'b1;
      write_enable_n <= 1'b1;
      address        <= 2'd0;
      data_out       <= 8'd0;
      rsp_valid      <= 1'b0;
      rsp_data       <= 16'd0;
      rsp_error      <= 1'b0;
      cnt            <= 8'd0;
      idx            <= 2'd0;
      last_idx       <= 2'd0;
      cur_read       <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            rsp_data <= 16'd0;
            idx      <= 2'd0;
            last_idx <= last_access(src_op, src_rw);
            if (src_counter == 2'd3) begin
              rsp_error <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              rsp_error     <= 1'b0;
              cur_read      <= first_info[10];
              address       <= first_info[9:8];
              data_out      <= first_info[7:0];
              chip_select_n <= 1'b0;
              state         <= SETUP;
            end
          end
        end
        SETUP: begin
          cnt <= 8'd0;
          if (cur_read)
            read_enable_n <= 1'b0;
          else
            write_enable_n <= 1'b0;
          state <= STROBE;
        end
        STROBE: begin
          if (cnt == (cur_read ? RD_LAST : WR_LAST)) begin
            read_enable_n  <= 1'b1;
            write_enable_n <= 1'b1;
            // First read of an LSB-carrying mode fills the low byte; everything else lands high.
            if (cur_read) begin
              if (idx == 2'd1 && f_rw != 2'b10)
                rsp_data[7:0] <= data_in;
              else
                rsp_data[15:8] <= data_in;
            end
            state <= HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          chip_select_n <= 1'b1;
          cnt           <= 8'd0;
          if (idx == last_idx) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            state <= RECOVER;
          end
        end
        RECOVER: begin
          if (cnt == REC_LAST) begin
            idx           <= idx + 2'd1;
            cur_read      <= next_info[10];
            address       <= next_info[9:8];
            data_out      <= next_info[7:0];
            chip_select_n <= 1'b0;
            state         <= SETUP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kf8253_program_sequencer.sv
// Self-checking bench for kf8253_program_sequencer: directed cases plus randomized requests
// checked against an access-list reference model and a bus monitor.
module tb_kf8253_program_sequencer;

  localparam int WR_PULSE = 2;
  localparam int RD_PULSE = 2;
  localparam int RECOVERY = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [1:0]  req_counter;
  logic [1:0]  req_rw_mode;
  logic [2:0]  req_mode;
  logic        req_bcd;
  logic [15:0] req_count;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_error;
  logic        chip_select_n;
  logic        read_enable_n;
  logic        write_enable_n;
  logic [1:0]  address;
  logic [7:0]  data_out;
  logic [7:0]  data_in;

  kf8253_program_sequencer #(
    .WR_PULSE(WR_PULSE), .RD_PULSE(RD_PULSE), .RECOVERY(RECOVERY)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_counter(req_counter), .req_rw_mode(req_rw_mode), .req_mode(req_mode),
    .req_bcd(req_bcd), .req_count(req_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .chip_select_n(chip_select_n), .read_enable_n(read_enable_n),
    .write_enable_n(write_enable_n), .address(address), .data_out(data_out),
    .data_in(data_in)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor log, one entry per chip-select window.
  logic       log_wr[$];
  logic [1:0] log_addr[$];
  logic [7:0] log_data[$];
  int         log_strobe[$];
  int         log_cs[$];
  int         log_gap[$];
  logic       overlap;
  logic [7:0] rd_bytes [2];
  logic [1:0] rd_idx;
  int         req_seq = 0;

  initial begin : bus_monitor
    int cs_len, st_len, gap, sgap, seen;
    logic wr_seen, prev_rd;
    logic [1:0] a;
    logic [7:0] d;
    cs_len = 0; st_len = 0; gap = 0; sgap = 0; seen = 0;
    wr_seen = 1'b0; prev_rd = 1'b1; a = 2'd0; d = 8'd0;
    data_in = 8'h00; overlap = 1'b0; rd_idx = 2'd0;
    forever begin
      @(negedge clock);
      if (seen != req_seq) begin
        seen = req_seq;
        log_wr.delete(); log_addr.delete(); log_data.delete();
        log_strobe.delete(); log_cs.delete(); log_gap.delete();
        overlap = 1'b0; rd_idx = 2'd0;
      end
      if (reset) begin
        cs_len = 0; st_len = 0; gap = 0; prev_rd = 1'b1;
      end else begin
        if (!read_enable_n && !write_enable_n) overlap = 1'b1;
        if (!chip_select_n) begin
          if (cs_len == 0) begin sgap = gap; wr_seen = 1'b0; a = 2'd0; d = 8'd0; end
          cs_len++; gap = 0;
          if (!write_enable_n) begin st_len++; wr_seen = 1'b1; a = address; d = data_out; end
          if (!read_enable_n) begin
            st_len++; a = address;
            if (rd_idx < 2'd2) data_in = rd_bytes[rd_idx[0]];
          end
          if (read_enable_n && !prev_rd) rd_idx = rd_idx + 2'd1;
        end else begin
          if (cs_len > 0) begin
            log_wr.push_back(wr_seen); log_addr.push_back(a); log_data.push_back(d);
            log_strobe.push_back(st_len); log_cs.push_back(cs_len); log_gap.push_back(sgap);
          end
          cs_len = 0; st_len = 0; gap++;
        end
        prev_rd = read_enable_n;
      end
    end
  end

  function automatic logic [7:0] logd(input int i);
    if (i < log_data.size()) return log_data[i];
    return 8'hxx;
  endfunction

  // Reference model: expected access list and response built from the request rules.
  logic       exp_wr[$];
  logic [1:0] exp_addr[$];
  logic [7:0] exp_data[$];

  task automatic add_acc(input logic w, input logic [1:0] a, input logic [7:0] d);
    exp_wr.push_back(w); exp_addr.push_back(a); exp_data.push_back(d);
  endtask

  task automatic scramble();
    req_op = 1'($urandom); req_counter = 2'($urandom); req_rw_mode = 2'($urandom);
    req_mode = 3'($urandom); req_bcd = 1'($urandom); req_count = 16'($urandom);
  endtask

  task automatic run_req(input string tag, input logic op, input logic [1:0] ctr,
                         input logic [1:0] rw, input logic [2:0] mode, input logic bcd,
                         input logic [15:0] count, input logic [7:0] b0, input logic [7:0] b1,
                         input int hold);
    logic [15:0] exp_rsp;
    logic        exp_err;
    int          exp_k, k, pulse;
    logic [16:0] held;
    exp_wr.delete(); exp_addr.delete(); exp_data.delete();
    exp_rsp = 16'd0; exp_err = 1'b0;
    if (ctr == 2'd3) begin
      exp_err = 1'b1;
    end else if (!op) begin
      add_acc(1'b1, 2'd3, {ctr, rw, mode, bcd});
      if (rw == 2'b01 || rw == 2'b11) add_acc(1'b1, ctr, count[7:0]);
      if (rw == 2'b10 || rw == 2'b11) add_acc(1'b1, ctr, count[15:8]);
    end else begin
      add_acc(1'b1, 2'd3, {ctr, 6'b000000});
      add_acc(1'b0, ctr, 8'h00);
      if (rw == 2'b01) exp_rsp = {8'h00, b0};
      else if (rw == 2'b10) exp_rsp = {b0, 8'h00};
      else begin add_acc(1'b0, ctr, 8'h00); exp_rsp = {b1, b0}; end
    end
    exp_k = 0;
    foreach (exp_wr[i]) exp_k += (exp_wr[i] ? WR_PULSE : RD_PULSE) + 2;
    if (exp_wr.size() > 1) exp_k += (exp_wr.size() - 1) * RECOVERY;
`ifdef KF8253_SEQ_QUEUE_EN
    exp_k += 1;
`endif
    rd_bytes[0] = b0; rd_bytes[1] = b1;

    @(negedge clock);
    req_op = op; req_counter = ctr; req_rw_mode = rw; req_mode = mode;
    req_bcd = bcd; req_count = count; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clock); k++; end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clock);
    req_seq++;
    @(negedge clock);
    req_valid = 1'b0;
    scramble();
    k = 0;
    while (!rsp_valid && k < 300) begin @(negedge clock); k++; end
    check({tag, "_latency"}, 32'(k), 32'(exp_k));
    check({tag, "_rsp"}, {15'd0, rsp_valid, rsp_error, rsp_data}, {15'd0, 1'b1, exp_err, exp_rsp});
    held = {rsp_error, rsp_data};
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check({tag, "_hold"}, {14'd0, rsp_valid, held}, {14'd0, 1'b1, exp_err, exp_rsp});
`ifndef KF8253_SEQ_QUEUE_EN
      check({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
`endif
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
`ifndef KF8253_SEQ_QUEUE_EN
    check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
`endif
    check({tag, "_n_acc"}, 32'(log_wr.size()), 32'(exp_wr.size()));
    check({tag, "_overlap"}, 32'(overlap), 32'd0);
    for (int i = 0; i < exp_wr.size() && i < log_wr.size(); i++) begin
      pulse = exp_wr[i] ? WR_PULSE : RD_PULSE;
      check($sformatf("%s_acc%0d", tag, i), {21'd0, log_wr[i], log_addr[i], log_data[i]},
            {21'd0, exp_wr[i], exp_addr[i], exp_data[i]});
      check($sformatf("%s_strobe%0d", tag, i), 32'(log_strobe[i]), 32'(pulse));
      check($sformatf("%s_cs%0d", tag, i), 32'(log_cs[i]), 32'(pulse + 2));
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), 32'(log_gap[i]), 32'(RECOVERY));
    end
  endtask

  initial begin : stimulus
    int k;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 1'b0; req_counter = 2'd0; req_rw_mode = 2'd0; req_mode = 3'd0;
    req_bcd = 1'b0; req_count = 16'd0;
    rd_bytes[0] = 8'h00; rd_bytes[1] = 8'h00;
    #1;
    check("reset_outputs",
          {9'd0, chip_select_n, read_enable_n, write_enable_n, address, data_out, req_ready, rsp_valid, rsp_error},
          {9'd0, 1'b1, 1'b1, 1'b1, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0});
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    run_req("prog_c0_rw11", 1'b0, 2'd0, 2'b11, 3'd3, 1'b0, 16'h1234, 8'h00, 8'h00, 1);
    check("prog_c0_ctrl", 32'(logd(0)), 32'h36);
    check("prog_c0_lsb", 32'(logd(1)), 32'h34);
    check("prog_c0_msb", 32'(logd(2)), 32'h12);

    run_req("rb_c2_rw11", 1'b1, 2'd2, 2'b11, 3'd0, 1'b0, 16'h0000, 8'hCD, 8'hAB, 0);
    check("rb_c2_latch", 32'(logd(0)), 32'h80);
    check("rb_c2_data", 32'(rsp_data), 32'hABCD);

    run_req("prog_c1_rw01", 1'b0, 2'd1, 2'b01, 3'd0, 1'b0, 16'h00FF, 8'h00, 8'h00, 0);
    check("prog_c1_ctrl", 32'(logd(0)), 32'h50);
    check("prog_c1_lsb", 32'(logd(1)), 32'hFF);

    run_req("illegal_c3", 1'b0, 2'd3, 2'b11, 3'd2, 1'b1, 16'hBEEF, 8'h00, 8'h00, 2);
    run_req("hold5", 1'b1, 2'd1, 2'b01, 3'd0, 1'b0, 16'h0000, 8'h5A, 8'h00, 5);
    run_req("rb_rw10", 1'b1, 2'd0, 2'b10, 3'd0, 1'b0, 16'h0000, 8'hC3, 8'h00, 0);
    run_req("rb_rw00", 1'b1, 2'd1, 2'b00, 3'd0, 1'b0, 16'h0000, 8'h12, 8'h34, 0);
    run_req("prog_latch", 1'b0, 2'd2, 2'b00, 3'd0, 1'b0, 16'h7777, 8'h00, 8'h00, 0);

    // Reset during the first write strobe aborts the request silently.
    @(negedge clock);
    req_op = 1'b0; req_counter = 2'd0; req_rw_mode = 2'b11; req_mode = 3'd3;
    req_bcd = 1'b0; req_count = 16'h1234; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clock); k++; end
    check("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clock);
    req_seq++;
    @(negedge clock);
    req_valid = 1'b0;
    k = 0;
    while (write_enable_n && k < 20) begin @(negedge clock); k++; end
    check("abort_strobe_seen", 32'(write_enable_n), 32'd0);
    reset = 1'b1;
    #1;
    check("abort_bus_idle", {29'd0, chip_select_n, write_enable_n, read_enable_n}, {29'd0, 3'b111});
    check("abort_rsp", {30'd0, rsp_valid, req_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("abort_quiet", {30'd0, rsp_valid, chip_select_n}, {30'd0, 1'b0, 1'b1});
    end
    run_req("after_abort", 1'b0, 2'd2, 2'b10, 3'd1, 1'b1, 16'hA55A, 8'h00, 8'h00, 0);

    for (int n = 0; n < 14; n++) begin
      run_req($sformatf("rand%0d", n), 1'($urandom), 2'($urandom_range(0, 3)), 2'($urandom),
              3'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 3)));
    end

`ifdef KF8253_SEQ_QUEUE_EN
    // Two back-to-back requests must both be accepted and complete in order.
    @(negedge clock);
    req_op = 1'b0; req_counter = 2'd0; req_rw_mode = 2'b01; req_mode = 3'd2;
    req_bcd = 1'b0; req_count = 16'h0011; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clock); k++; end
    check("q_ready_a", 32'(req_ready), 32'd1);
    @(posedge clock);
    req_seq++;
    @(negedge clock);
    req_counter = 2'd1; req_rw_mode = 2'b10; req_count = 16'h2200;
    check("q_ready_b", 32'(req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      k = 0;
      while (!rsp_valid && k < 300) begin @(negedge clock); k++; end
      check($sformatf("q_rsp%0d", r), {15'd0, rsp_valid, rsp_error, rsp_data}, {15'd0, 1'b1, 1'b0, 16'd0});
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
    end
    check("q_n_acc", 32'(log_data.size()), 32'd4);
    check("q_order", {logd(0), logd(1), logd(2), logd(3)}, 32'h14_11_64_22);
`endif

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
